// File: rtl/moore_fsm_seq_ctrl.sv
// moore_fsm_seq_ctrl: built-in test sequencer for the lab serial-input Moore FSM.
// Resets the FSM, shifts a stored W pattern in LSB first, samples Zout after
// every bit against an expected vector and reports done/pass/err_cnt/fail_idx.
// Each step takes two cycles: DRIVE presents W[idx], CHECK holds it and compares Z.
// Optional build macro: SEQ_STOP_ON_FAIL_EN -- end the run on the first mismatch.
// RST_CYC must be at least 1.
module moore_fsm_seq_ctrl #(
    parameter int PAT_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int RST_CYC = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic [PAT_LEN-1:0] expect_z,
    input  logic [LEN_W-1:0]   len,
    output logic               W,
    output logic               fsm_reset_n,
    input  logic               Z,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [LEN_W-1:0]   err_cnt,
    output logic [LEN_W-1:0]   fail_idx
);

    localparam int                 RCNT_W   = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RCNT_W-1:0]  RST_LAST = RCNT_W'(RST_CYC - 1);
    localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(PAT_LEN);

    typedef enum logic [2:0] {
        IDLE,
        RST,
        DRIVE,
        CHECK,
        DONE
    } state_t;

    state_t              state;
    logic [PAT_LEN-1:0]  pat_q;
    logic [PAT_LEN-1:0]  exp_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    idx;
    logic [RCNT_W-1:0]   rst_cnt;

    logic [LEN_W-1:0]    len_clamp;
    logic [LEN_W-1:0]    idx_nxt;
    logic                pat_nxt_bit;
    logic                exp_bit;
    logic                mismatch;
    logic                last_step;
    logic                finish_run;
    logic                run_phase;

    // Clamp the requested length and derive per-step control terms
    always_comb begin
        len_clamp = (len > LEN_MAX) ? LEN_MAX : len;
        idx_nxt   = idx + LEN_W'(1);
        last_step = (idx == len_q - LEN_W'(1));
        run_phase = (state == RST) || (state == DRIVE) || (state == CHECK);
    end

    // Select the expected bit for the current step and the W bit for the next one
    always_comb begin
        exp_bit     = 1'b0;
        pat_nxt_bit = 1'b0;
        for (int unsigned i = 0; i < PAT_LEN; i++) begin
            if (idx == LEN_W'(i)) begin
                exp_bit = exp_q[i];
            end
            if (idx_nxt == LEN_W'(i)) begin
                pat_nxt_bit = pat_q[i];
            end
        end
    end

    // Decide whether the current CHECK step closes the run
    always_comb begin
        mismatch = (Z != exp_bit);
`ifdef SEQ_STOP_ON_FAIL_EN
        finish_run = last_step || mismatch;
`else
        finish_run = last_step;
`endif
    end

    // Sequencer state machine with all outputs registered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            W           <= 1'b0;
            fsm_reset_n <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            err_cnt     <= '0;
            fail_idx    <= '0;
            idx         <= '0;
            rst_cnt     <= '0;
            pat_q       <= '0;
            exp_q       <= '0;
            len_q       <= '0;
        end else begin
            done <= 1'b0;
            if (abort && run_phase) begin
                // err_cnt and fail_idx keep their partial values
                state       <= IDLE;
                W           <= 1'b0;
                fsm_reset_n <= 1'b1;
                busy        <= 1'b0;
                pass        <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        W           <= 1'b0;
                        fsm_reset_n <= 1'b1;
                        if (start && !abort) begin
                            pat_q       <= pattern;
                            exp_q       <= expect_z;
                            len_q       <= len_clamp;
                            idx         <= '0;
                            err_cnt     <= '0;
                            fail_idx    <= '0;
                            pass        <= 1'b0;
                            busy        <= 1'b1;
                            rst_cnt     <= '0;
                            fsm_reset_n <= 1'b0;
                            state       <= RST;
                        end
                    end
                    RST: begin
                        W <= 1'b0;
                        if (rst_cnt == RST_LAST) begin
                            fsm_reset_n <= 1'b1;
                            if (len_q == '0) begin
                                state <= DONE;
                            end else begin
                                W     <= pat_q[0];
                                state <= DRIVE;
                            end
                        end else begin
                            rst_cnt <= rst_cnt + RCNT_W'(1);
                        end
                    end
                    DRIVE: begin
                        state <= CHECK;
                    end
                    CHECK: begin
                        if (mismatch) begin
                            if (err_cnt != '1) begin
                                err_cnt <= err_cnt + LEN_W'(1);
                            end
                            if (err_cnt == '0) begin
                                fail_idx <= idx;
                            end
                        end
                        if (finish_run) begin
                            W     <= 1'b0;
                            state <= DONE;
                        end else begin
                            idx   <= idx_nxt;
                            W     <= pat_nxt_bit;
                            state <= DRIVE;
                        end
                    end
                    DONE: begin
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        pass        <= (len_q == '0) || (err_cnt == '0);
                        W           <= 1'b0;
                        fsm_reset_n <= 1'b1;
                        state       <= IDLE;
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_moore_fsm_seq_ctrl.sv
// tb_moore_fsm_seq_ctrl: bench for moore_fsm_seq_ctrl with a lab FSM
// (Zout=1 iff the last two W inputs were 1) and a timeline-based reference model.
module tb_moore_fsm_seq_ctrl;

    localparam int PAT_LEN = 8;
    localparam int LEN_W   = 4;
    localparam int RST_CYC = 2;
    localparam int ERR_MAX = (1 << LEN_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [7:0]       pattern = '0;
    logic [7:0]       expect_z = '0;
    logic [3:0]       len = '0;
    logic             W, fsm_reset_n, Z, busy, done, pass;
    logic [3:0]       err_cnt, fail_idx;

    int unsigned      n_chk = 0;
    int unsigned      n_pass = 0;
    bit               chk_en = 1'b0;

    moore_fsm_seq_ctrl #(
        .PAT_LEN(PAT_LEN),
        .LEN_W  (LEN_W),
        .RST_CYC(RST_CYC)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .expect_z   (expect_z),
        .len        (len),
        .W          (W),
        .fsm_reset_n(fsm_reset_n),
        .Z          (Z),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_cnt    (err_cnt),
        .fail_idx   (fail_idx)
    );

    always #5 clk = ~clk;

    // Lab FSM under test: Zout=1 iff the last two sampled W were 1
    logic lab_prev, lab_z;
    always_ff @(posedge clk or negedge fsm_reset_n) begin
        if (!fsm_reset_n) begin
            lab_prev <= 1'b0;
            lab_z    <= 1'b0;
        end else begin
            lab_z    <= W & lab_prev;
            lab_prev <= W;
        end
    end
    assign Z = lab_z;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Zout the lab FSM must show after step i: W[i] & W[i-1], nothing before step 0
    function automatic logic [7:0] ideal_z(input logic [7:0] p);
        logic [7:0] z;
        z = '0;
        for (int i = 1; i < 8; i++) z[i] = p[i] & p[i-1];
        return z;
    endfunction

    // Reference model: outputs as a function of edges elapsed since the start edge
    int unsigned m_w = 0, m_frst = 0, m_busy = 0, m_done = 0, m_pass = 0;
    int unsigned m_err = 0, m_fidx = 0;
    int unsigned m_t = 0, m_len = 0, m_L = 0;
    bit          m_run = 1'b0;
    logic [7:0]  m_pat = '0, m_mis = '0;

    initial forever begin
        int unsigned k, s;
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            m_w = 0; m_frst = 0; m_busy = 0; m_done = 0; m_pass = 0;
            m_err = 0; m_fidx = 0; m_run = 1'b0; m_t = 0;
        end else begin
            m_done = 0;
            if (!m_run) begin
                m_w = 0;
                m_frst = 1;
                if (start && !abort) begin
                    m_pat = pattern;
                    m_len = (int'(len) > PAT_LEN) ? PAT_LEN : len;
                    m_mis = ideal_z(pattern) ^ expect_z;
                    m_L = m_len;
`ifdef SEQ_STOP_ON_FAIL_EN
                    for (int i = int'(m_len) - 1; i >= 0; i--) if (m_mis[i]) m_L = i + 1;
`endif
                    m_run = 1'b1; m_t = 0; m_busy = 1; m_pass = 0;
                    m_err = 0; m_fidx = 0; m_frst = 0;
                end
            end else begin
                k = m_t + 1;
                if (abort && k <= RST_CYC + 2 * m_L) begin
                    m_run = 1'b0; m_busy = 0; m_pass = 0; m_w = 0; m_frst = 1;
                end else begin
                    m_t = k;
                    m_frst = (k >= RST_CYC) ? 1 : 0;
                    m_w = (k >= RST_CYC && k < RST_CYC + 2 * m_L) ? 32'(m_pat[(k - RST_CYC) / 2]) : 0;
                    if (k >= RST_CYC + 2 && k <= RST_CYC + 2 * m_L && ((k - RST_CYC) % 2) == 0) begin
                        s = (k - RST_CYC) / 2 - 1;
                        if (m_mis[s]) begin
                            if (m_err == 0) m_fidx = s;
                            if (m_err != ERR_MAX) m_err++;
                        end
                    end
                    if (k == RST_CYC + 2 * m_L + 1) begin
                        m_done = 1; m_busy = 0; m_run = 1'b0;
                        m_pass = (m_len == 0 || m_err == 0) ? 1 : 0;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("W", 32'(W), m_w);
            check("fsm_reset_n", 32'(fsm_reset_n), m_frst);
            check("busy", 32'(busy), m_busy);
            check("done", 32'(done), m_done);
            check("pass", 32'(pass), m_pass);
            check("err_cnt", 32'(err_cnt), m_err);
            check("fail_idx", 32'(fail_idx), m_fidx);
        end
    end

    // One run from posedge+1; lat counts edges from the start edge to the done edge
    task automatic do_run(input logic [7:0] p, input logic [7:0] e, input logic [3:0] l,
                          input bit poke, output int lat, output logic [7:0] wbits,
                          output int rlo, output int whi, output logic ps,
                          output logic [3:0] ec, output logic [3:0] fi);
        pattern = p; expect_z = e; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = -1; wbits = '0; rlo = 0; whi = 0; ps = 1'bx; ec = 'x; fi = 'x;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (poke && k == 6) begin
                start = 1'b1; pattern = ~p; expect_z = ~e; len = 4'd3;
            end
            if (poke && k == 7) start = 1'b0;
            if (!fsm_reset_n) rlo++;
            if (W) whi++;
            for (int i = 0; i < 8; i++) if (k == 3 + 2 * i) wbits[i] = W;
            if (done) begin
                lat = k - 1; ps = pass; ec = err_cnt; fi = fail_idx;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int lat, rlo, whi, dn;
        logic [7:0] wb;
        logic ps;
        logic [3:0] ec, fi;

        // Asynchronous reset asserted mid-clock
        #3 reset_n = 1'b0;
        #1;
        check("rst_W", 32'(W), 0);
        check("rst_fsm_reset_n", 32'(fsm_reset_n), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_err_cnt", 32'(err_cnt), 0);
        check("rst_fail_idx", 32'(fail_idx), 0);
        chk_en = 1'b1;
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("rel_fsm_reset_n", 32'(fsm_reset_n), 1);
        check("rel_busy", 32'(busy), 0);

        // Passing run, with a start pulse while busy that must be ignored
        do_run(8'h6E, 8'h4C, 4'd8, 1'b1, lat, wb, rlo, whi, ps, ec, fi);
        check("pass_latency", lat, 19);
        check("pass_wseq", 32'(wb), 32'h6E);
        check("pass_rst_cycles", rlo, 2);
        check("pass_pass", 32'(ps), 1);
        check("pass_err_cnt", 32'(ec), 0);

        // Failing run: bit 0 expected high, lab FSM gives 0
        do_run(8'h6E, 8'h4D, 4'd8, 1'b0, lat, wb, rlo, whi, ps, ec, fi);
`ifdef SEQ_STOP_ON_FAIL_EN
        check("fail_latency", lat, 5);
`else
        check("fail_latency", lat, 19);
`endif
        check("fail_pass", 32'(ps), 0);
        check("fail_err_cnt", 32'(ec), 1);
        check("fail_fail_idx", 32'(fi), 0);

        // len=0: straight from reset to done
        do_run(8'hFF, 8'h00, 4'd0, 1'b0, lat, wb, rlo, whi, ps, ec, fi);
        check("len0_latency", lat, 3);
        check("len0_pass", 32'(ps), 1);
        check("len0_w_high", whi, 0);
        check("len0_rst_cycles", rlo, 2);

        // len=12 clamps to 8
        do_run(8'h6E, 8'h4C, 4'd12, 1'b0, lat, wb, rlo, whi, ps, ec, fi);
        check("len12_latency", lat, 19);
        check("len12_wseq", 32'(wb), 32'h6E);
        check("len12_pass", 32'(ps), 1);

        // start and abort together in IDLE: request dropped
        pattern = 8'h6E; expect_z = 8'h4C; len = 4'd8;
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("sa_busy", 32'(busy), 0);
        check("sa_fsm_reset_n", 32'(fsm_reset_n), 1);

        // Abort during step 3 (DRIVE entered on edge 8 after start)
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("ab_busy", 32'(busy), 0);
        check("ab_W", 32'(W), 0);
        check("ab_fsm_reset_n", 32'(fsm_reset_n), 1);
        check("ab_pass", 32'(pass), 0);
        dn = 0;
        repeat (25) begin
            @(negedge clk);
            if (done) dn++;
        end
        check("ab_no_done", dn, 0);
        @(posedge clk); #1;

        // reset_n pulsed mid-run after a mismatch has been counted
        pattern = 8'h6E; expect_z = 8'h4D; len = 4'd8; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mr_W", 32'(W), 0);
        check("mr_fsm_reset_n", 32'(fsm_reset_n), 0);
        check("mr_busy", 32'(busy), 0);
        check("mr_done", 32'(done), 0);
        check("mr_pass", 32'(pass), 0);
        check("mr_err_cnt", 32'(err_cnt), 0);
        check("mr_fail_idx", 32'(fail_idx), 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("mr_rel_fsm_reset_n", 32'(fsm_reset_n), 1);

        // Randomized traffic: inputs change every cycle, model tracks everything
        for (int c = 0; c < 4000; c++) begin
            start   = ($urandom_range(7) == 0);
            abort   = ($urandom_range(59) == 0);
            pattern = 8'($urandom);
            len     = 4'($urandom_range(15));
            if ($urandom_range(1) == 0) expect_z = ideal_z(pattern);
            else if ($urandom_range(1) == 0) expect_z = ideal_z(pattern) ^ (8'h01 << $urandom_range(7));
            else expect_z = 8'($urandom);
            @(posedge clk); #1;
        end
        start = 1'b0;
        abort = 1'b0;
        repeat (30) @(posedge clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
